// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: applies EX-stage redirects (branch/JAL, JALR, trap), flushes IF/ID and ID/EX.
// Optional macro MISALIGN_TRAP_EN turns misaligned branch/JALR targets into traps.
`timescale 1ns/1ps
module pc_redirect_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter logic [XLEN-1:0] TRAP_VEC     = 'h100,
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] alu_target,
    input  logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] pc,
    output logic            flush,
    output logic [XLEN-1:0] epc,
    output logic            trap_taken,
    output logic            misalign
);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    localparam logic [1:0] CntInit = 2'(FLUSH_CYCLES - 1);

    state_e          state_q;
    logic [1:0]      cnt_q;
    logic [XLEN-1:0] pc_q, epc_q;
    logic            flush_q, trap_q;

    logic [XLEN-1:0] pc_inc, tgt;
    logic            redirect, bad_align, is_trap;

    always_comb begin
        pc_inc    = pc_q + XLEN'(4);
        redirect  = (state_q == StRun) && ex_valid && (pc_sel != 2'b00);
        bad_align = 1'b0;
        case (pc_sel)
            2'b10:   tgt = br_target;
            2'b01:   tgt = alu_target & ~XLEN'(1);
            2'b11:   tgt = TRAP_VEC;
            default: tgt = pc_inc;
        endcase
`ifdef MISALIGN_TRAP_EN
        // Only computed jump targets are checked; the trap vector is trusted.
        bad_align = ((pc_sel == 2'b01) || (pc_sel == 2'b10)) && (tgt[1:0] != 2'b00);
        if (bad_align) tgt = TRAP_VEC;
`endif
        is_trap = (pc_sel == 2'b11) || bad_align;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= 2'd0;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            flush_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            trap_q <= 1'b0;
            case (state_q)
                StRun: begin
                    if (redirect) begin
                        pc_q    <= tgt;
                        flush_q <= 1'b1;
                        cnt_q   <= CntInit;
                        state_q <= StFlush;
                        if (is_trap) begin
                            epc_q  <= ex_pc;
                            trap_q <= 1'b1;
                        end
                    end else begin
                        flush_q <= 1'b0;
                        if (!stall) pc_q <= pc_inc;
                    end
                end
                StFlush: begin
                    // EX contents belong to squashed instructions; redirects are ignored here.
                    if (!stall) pc_q <= pc_inc;
                    if (cnt_q == 2'd0) begin
                        flush_q <= 1'b0;
                        state_q <= StRun;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic mis_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mis_q <= 1'b0;
        else     mis_q <= redirect && bad_align;
    end
    assign misalign = mis_q;
`else
    assign misalign = 1'b0;
`endif

    assign pc         = pc_q;
    assign flush      = flush_q;
    assign epc        = epc_q;
    assign trap_taken = trap_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit; expectations follow MISALIGN_TRAP_EN when defined.
`timescale 1ns/1ps
module tb_pc_redirect_unit;

`ifdef MISALIGN_TRAP_EN
    localparam bit Mis = 1'b1;
`else
    localparam bit Mis = 1'b0;
`endif

    logic        clk, rst, stall, ex_valid, flush, trap_taken, misalign;
    logic [1:0]  pc_sel;
    logic [31:0] br_target, alu_target, ex_pc, pc, epc;
    logic [31:0] exp_pc, exp_epc;
    int          checks, errors;

    pc_redirect_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .pc_sel     (pc_sel),
        .br_target  (br_target),
        .alu_target (alu_target),
        .ex_pc      (ex_pc),
        .pc         (pc),
        .flush      (flush),
        .epc        (epc),
        .trap_taken (trap_taken),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; ex_valid = 1'b0; pc_sel = 2'b00;
        br_target = '0; alu_target = '0; ex_pc = '0;
        #3;
        checks++;
        if ({pc, flush, epc, trap_taken, misalign} !== {32'h0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: pc=%h flush=%b epc=%h trap=%b mis=%b required 0", pc, flush,
                     epc, trap_taken, misalign);
        end
        step();
        rst = 1'b0;
        checks++;
        if (pc !== 32'h0) begin errors++; $display("FAIL reset_release: pc=%h required 0", pc); end
        step();
        checks++;
        if (pc !== 32'h4) begin errors++; $display("FAIL seq_1: pc=%h required 4", pc); end
        step();
        checks++;
        if (pc !== 32'h8) begin errors++; $display("FAIL seq_2: pc=%h required 8", pc); end
    endtask

    task automatic test_branch();
        ex_valid = 1'b1; pc_sel = 2'b10; br_target = 32'h40;
        step();
        checks++;
        if ({pc, flush} !== {32'h40, 1'b1}) begin
            errors++; $display("FAIL branch_take: pc=%h flush=%b required 40/1", pc, flush);
        end
        br_target = 32'h200;  // ignored while flushing
        step();
        checks++;
        if ({pc, flush} !== {32'h44, 1'b1}) begin
            errors++; $display("FAIL branch_flush2: pc=%h flush=%b required 44/1", pc, flush);
        end
        step();
        checks++;
        if ({pc, flush} !== {32'h48, 1'b0}) begin
            errors++; $display("FAIL branch_end: pc=%h flush=%b required 48/0", pc, flush);
        end
        ex_valid = 1'b0;
        step();
        checks++;
        if ({pc, flush} !== {32'h4C, 1'b0}) begin
            errors++; $display("FAIL branch_seq: pc=%h flush=%b required 4c/0", pc, flush);
        end
    endtask

    task automatic test_jalr();
        ex_valid = 1'b1; pc_sel = 2'b01; alu_target = 32'h205; ex_pc = 32'h30;
        step();
        checks++;
        if ({pc, flush, trap_taken} !== {32'h204, 1'b1, 1'b0}) begin
            errors++; $display("FAIL jalr_aligned: pc=%h flush=%b trap=%b required 204/1/0", pc,
                               flush, trap_taken);
        end
        ex_valid = 1'b0;
        step();
        step();
        ex_valid = 1'b1; alu_target = 32'h123;
        step();
        exp_pc  = Mis ? 32'h100 : 32'h122;
        exp_epc = Mis ? 32'h30 : 32'h0;
        checks++;
        if ({pc, epc, misalign, trap_taken} !== {exp_pc, exp_epc, Mis, Mis}) begin
            errors++; $display("FAIL jalr_clear_bit0: pc=%h epc=%h mis=%b trap=%b required %h/%h/%b",
                               pc, epc, misalign, trap_taken, exp_pc, exp_epc, Mis);
        end
        ex_valid = 1'b0;
        step();
        step();
        exp_pc = exp_pc + 32'h8;
        checks++;
        if ({pc, flush} !== {exp_pc, 1'b0}) begin
            errors++; $display("FAIL jalr_resume: pc=%h flush=%b required %h/0", pc, flush, exp_pc);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1; ex_valid = 1'b1; pc_sel = 2'b00;
        step();
        checks++;
        if ({pc, flush} !== {exp_pc, 1'b0}) begin
            errors++; $display("FAIL stall_hold: pc=%h required %h", pc, exp_pc);
        end
        pc_sel = 2'b10; br_target = 32'h80;
        step();
        checks++;
        if ({pc, flush} !== {32'h80, 1'b1}) begin
            errors++; $display("FAIL stall_redirect: pc=%h flush=%b required 80/1", pc, flush);
        end
        ex_valid = 1'b0;
        step();
        step();
        checks++;
        if ({pc, flush} !== {32'h80, 1'b0}) begin
            errors++; $display("FAIL stall_in_flush: pc=%h flush=%b required 80/0", pc, flush);
        end
        stall = 1'b0;
        step();
        checks++;
        if (pc !== 32'h84) begin errors++; $display("FAIL stall_release: pc=%h required 84", pc); end
    endtask

    task automatic test_trap();
        ex_valid = 1'b1; pc_sel = 2'b11; ex_pc = 32'h2C;
        step();
        checks++;
        if ({pc, epc, trap_taken, flush} !== {32'h100, 32'h2C, 1'b1, 1'b1}) begin
            errors++; $display("FAIL trap_entry: pc=%h epc=%h trap=%b flush=%b required 100/2c/1/1",
                               pc, epc, trap_taken, flush);
        end
        ex_valid = 1'b0;
        step();
        checks++;
        if ({pc, trap_taken} !== {32'h104, 1'b0}) begin
            errors++; $display("FAIL trap_pulse: pc=%h trap=%b required 104/0", pc, trap_taken);
        end
        step();
        ex_pc = 32'h50;
        step();
        checks++;
        if ({pc, epc, trap_taken} !== {32'h10C, 32'h2C, 1'b0}) begin
            errors++; $display("FAIL trap_not_valid: pc=%h epc=%h trap=%b required 10c/2c/0", pc,
                               epc, trap_taken);
        end
    endtask

    task automatic test_back_to_back();
        ex_valid = 1'b1; pc_sel = 2'b11; ex_pc = 32'h60;
        step();
        ex_pc = 32'h70;
        step();
        checks++;
        if ({pc, epc, trap_taken} !== {32'h104, 32'h60, 1'b0}) begin
            errors++; $display("FAIL b2b_ignored: pc=%h epc=%h trap=%b required 104/60/0", pc, epc,
                               trap_taken);
        end
        step();
        step();
        checks++;
        if ({pc, epc, trap_taken} !== {32'h100, 32'h70, 1'b1}) begin
            errors++; $display("FAIL b2b_overwrite: pc=%h epc=%h trap=%b required 100/70/1", pc,
                               epc, trap_taken);
        end
        ex_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_misalign();
        ex_valid = 1'b1; pc_sel = 2'b10; br_target = 32'h42; ex_pc = 32'h10;
        step();
        exp_pc  = Mis ? 32'h100 : 32'h42;
        exp_epc = Mis ? 32'h10 : 32'h70;
        checks++;
        if ({pc, epc, misalign, trap_taken, flush} !== {exp_pc, exp_epc, Mis, Mis, 1'b1}) begin
            errors++; $display("FAIL misalign_branch: pc=%h epc=%h mis=%b trap=%b flush=%b required %h/%h/%b",
                               pc, epc, misalign, trap_taken, flush, exp_pc, exp_epc, Mis);
        end
        ex_valid = 1'b0;
        step();
        checks++;
        if ({misalign, trap_taken} !== 2'b00) begin
            errors++; $display("FAIL misalign_pulse: mis=%b trap=%b required 0/0", misalign,
                               trap_taken);
        end
        step();
    endtask

    task automatic test_wrap();
        ex_valid = 1'b1; pc_sel = 2'b10; br_target = 32'hFFFF_FFF8;
        step();
        ex_valid = 1'b0;
        step();
        checks++;
        if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre: pc=%h required fffffffc", pc); end
        step();
        checks++;
        if ({pc, flush} !== {32'h0, 1'b0}) begin
            errors++; $display("FAIL wrap_zero: pc=%h flush=%b required 0/0", pc, flush);
        end
    endtask

    task automatic test_reset_mid_flush();
        ex_valid = 1'b1; pc_sel = 2'b10; br_target = 32'h300;
        step();
        ex_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({pc, flush, epc, trap_taken} !== {32'h0, 1'b0, 32'h0, 1'b0}) begin
            errors++; $display("FAIL reset_async: pc=%h flush=%b epc=%h trap=%b required 0", pc,
                               flush, epc, trap_taken);
        end
        #1 rst = 1'b0;
        ex_valid = 1'b1; br_target = 32'h500;
        step();
        checks++;
        if ({pc, flush} !== {32'h500, 1'b1}) begin
            errors++; $display("FAIL reset_abort_flush: pc=%h flush=%b required 500/1", pc, flush);
        end
        ex_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_branch();
        test_jalr();
        test_stall();
        test_trap();
        test_back_to_back();
        test_misalign();
        test_wrap();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Owns the architectural fetch PC and acts on the 2-bit PC-selection code from the branch control logic in EX: 00 sequential, 01 JALR, 10 branch/JAL, 11 ECALL/EBREAK trap.
- Drives the fetch address, generates the pipeline flush after every redirect, and records the exception PC on trap entry.
- Sits between the EX-stage branch decision and the IF stage.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, fetch address on trap entry.
- FLUSH_CYCLES, 2, number of cycles flush stays high after a redirect (1..3); counter width is 2 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall; holds the PC when no redirect is taken.
- ex_valid  in  1  EX stage holds a live (non-bubble) instruction.
- pc_sel  in  2  selection code from the branch controls.
- br_target  in  XLEN  PC+imm adder result (branch/JAL).
- alu_target  in  XLEN  ALU result (JALR, rs1+imm).
- ex_pc  in  XLEN  PC of the instruction in EX.
- pc  out  XLEN  registered fetch address.
- flush  out  1  registered; kills the IF/ID and ID/EX contents.
- epc  out  XLEN  registered exception PC.
- trap_taken  out  1  registered single-cycle pulse on trap entry.
- misalign  out  1  registered single-cycle pulse (optional feature only; otherwise tied 0).

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high.
- Reset values: pc=RESET_PC, flush=0, epc=0, trap_taken=0, misalign=0, state=RUN, flush counter=0. Reset asserted mid-FLUSH aborts the flush immediately.
- A redirect is accepted only when state==RUN, ex_valid=1, and pc_sel!=00.
- Target selection:
  - 10 -> br_target.
  - 01 -> {alu_target[XLEN-1:1],1'b0}.
  - 11 -> TRAP_VEC; epc<=ex_pc; trap_taken=1 for exactly one cycle.
- Latency: a redirect sampled at edge N makes pc=target after edge N. flush is high for the FLUSH_CYCLES cycles following edge N.
- Priority: an accepted redirect overrides stall. Otherwise stall=1 holds pc; stall=0 gives pc<=pc+4 (modulo 2^XLEN, wraps 32'hFFFF_FFFC -> 0).
- State RUN:
  - Redirect -> FLUSH, counter<=FLUSH_CYCLES-1, flush<=1.
  - Otherwise stay in RUN with flush=0.
- State FLUSH:
  - pc_sel and ex_valid are ignored, since they belong to instructions being squashed.
  - pc advances by +4 unless stall.
  - Counter decrements each cycle. At 0: flush<=0 and state returns to RUN.
  - FLUSH_CYCLES=1 means FLUSH lasts exactly one cycle.
- ex_valid=0 with any pc_sel: no redirect, sequential behaviour.
- pc_sel=00 never changes state or epc.
- epc changes only on trap entry; back-to-back traps overwrite it.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Before acceptance, the computed target (after the JALR bit-0 clear) is checked for target[1:0]!=0, for codes 01/10 only.
  - If misaligned: epc<=ex_pc, pc<=TRAP_VEC, misalign and trap_taken pulse for one cycle, and the normal FLUSH sequence runs.
  - Code 11 is never checked.
- Undefined: targets are used unmodified, and misalign is constant 0.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle -> pc=0, flush=0, epc=0 immediately. Release, stall=0 -> pc=0,4,8 on successive edges.
- Branch: ex_valid=1, pc_sel=10, br_target=32'h40 at edge N -> pc=32'h40 after N, flush=1 for 2 cycles. pc_sel=10 presented during those cycles is ignored; then pc=32'h44, 32'h48.
- JALR: pc_sel=01, alu_target=32'h123 -> pc=32'h122.
- Stall vs redirect: stall=1 with pc_sel=00 -> pc held. stall=1 with pc_sel=10, br_target=32'h80 -> pc=32'h80 (redirect wins).
- Trap: pc_sel=11, ex_pc=32'h2C -> pc=32'h100, epc=32'h2C, trap_taken pulse of exactly 1 cycle. ex_valid=0 with pc_sel=11 -> no trap, pc+4.
- Optional feature with MISALIGN_TRAP_EN: pc_sel=10, br_target=32'h42, ex_pc=32'h10 -> pc=32'h100, epc=32'h10, misalign=1 for 1 cycle. Without the macro: pc=32'h42.
